// File: rtl/rand_delay_pkg.sv
// Shared definitions for the random-delay timer: FSM state encoding,
// maximal-length LFSR tap table and the LFSR seed.
package rand_delay_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_COUNTING = 2'b01,
        ST_FIRE     = 2'b10,
        ST_WAIT_LOW = 2'b11
    } state_e;

    // A non-zero seed keeps the LFSR out of its all-zero lock-up state.
    localparam int unsigned LFSR_SEED = 1;

    // Galois (right-shift) feedback masks giving a maximal-length sequence.
    function automatic logic [15:0] lfsr_taps(input int unsigned n);
        logic [15:0] taps;
        case (n)
            1:       taps = 16'h0001;
            2:       taps = 16'h0003;
            3:       taps = 16'h0006;
            4:       taps = 16'h000C;
            5:       taps = 16'h0014;
            6:       taps = 16'h0030;
            7:       taps = 16'h0060;
            8:       taps = 16'h00B8;
            9:       taps = 16'h0110;
            10:      taps = 16'h0240;
            11:      taps = 16'h0500;
            12:      taps = 16'h0829;
            13:      taps = 16'h100D;
            14:      taps = 16'h2015;
            15:      taps = 16'h6000;
            16:      taps = 16'hD008;
            default: taps = 16'h0060;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/rand_delay_timer_lfsr.sv
// Free-running N-bit Galois LFSR used as the random delay offset source.
module lfsr_n
    import rand_delay_pkg::*;
#(
    parameter int N = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [N-1:0] data_out
);

    localparam logic [15:0]  TAPS16 = lfsr_taps(N);
    localparam logic [N-1:0] TAPS   = N'(TAPS16);
    localparam logic [N-1:0] SEED   = N'(LFSR_SEED);

    logic [N-1:0] lfsr_q;
    logic [N-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign data_out = lfsr_q;

endmodule

// File: rtl/rand_delay_timer.sv
// Trigger-to-pulse delay timer with fixed or LFSR-randomised delay,
// abortable countdown and a configurable-width time_out pulse.
module rand_delay_timer
    import rand_delay_pkg::*;
#(
    parameter int WIDTH     = 10,
    parameter int RAND_W    = 7,
    parameter int PULSE_LEN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trigger,
    input  logic             abort,
    input  logic             mode_rand,
    input  logic [WIDTH-1:0] delay_fixed,
    input  logic [WIDTH-1:0] delay_min,
    output logic             time_out,
    output logic             busy,
    output logic [WIDTH-1:0] count
);

    localparam int              PCNT_W    = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam logic [PCNT_W-1:0] PCNT_LOAD = PCNT_W'(PULSE_LEN - 1);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  count_q, count_d;
    logic [PCNT_W-1:0] pcnt_q, pcnt_d;
    logic [RAND_W-1:0] lfsr_val;

    // Sum is formed one bit wider so an overflow clamps to all-ones.
    function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[WIDTH] ? '1 : sum[WIDTH-1:0];
    endfunction

    lfsr_n #(
        .N (RAND_W)
    ) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (1'b1),
        .data_out (lfsr_val)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pcnt_d  = pcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (trigger && !abort) begin
                    count_d = mode_rand ? sat_add(delay_min, WIDTH'(lfsr_val)) : delay_fixed;
                    state_d = ST_COUNTING;
                end
            end
            ST_COUNTING: begin
                if (abort) begin
                    count_d = '0;
                    state_d = ST_IDLE;
                end else if (count_q != '0) begin
                    count_d = count_q - WIDTH'(1);
                end else begin
                    pcnt_d  = PCNT_LOAD;
                    state_d = ST_FIRE;
                end
            end
            ST_FIRE: begin
                if (abort) begin
                    pcnt_d  = '0;
                    state_d = ST_IDLE;
                end else if (pcnt_q != '0) begin
                    pcnt_d = pcnt_q - PCNT_W'(1);
                end else begin
                    // A still-held trigger must drop before the next arm.
                    state_d = trigger ? ST_WAIT_LOW : ST_IDLE;
                end
            end
            ST_WAIT_LOW: begin
                if (!trigger) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                count_d = '0;
                pcnt_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            pcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pcnt_q  <= pcnt_d;
        end
    end

    assign time_out = (state_q == ST_FIRE);
    assign busy     = (state_q == ST_COUNTING) || (state_q == ST_FIRE);
    assign count    = (state_q == ST_COUNTING) ? count_q : '0;

endmodule

// File: tb/tb_rand_delay_timer.sv
// Directed bench for rand_delay_timer: fixed/random delays, pulse width,
// saturation, abort, held trigger and asynchronous reset.
module tb_rand_delay_timer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Default configuration instance
    logic       a_trig, a_abort, a_mode;
    logic [9:0] a_fixed, a_min, a_count;
    logic       a_to, a_busy;

    // PULSE_LEN = 3 instance
    logic       p_trig, p_abort, p_mode;
    logic [9:0] p_fixed, p_min, p_count;
    logic       p_to, p_busy;

    // WIDTH = 8 instance
    logic       w_trig, w_abort, w_mode;
    logic [7:0] w_fixed, w_min, w_count;
    logic       w_to, w_busy;

    rand_delay_timer #(.WIDTH(10), .RAND_W(7), .PULSE_LEN(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .trigger(a_trig), .abort(a_abort), .mode_rand(a_mode),
        .delay_fixed(a_fixed), .delay_min(a_min), .time_out(a_to), .busy(a_busy), .count(a_count)
    );

    rand_delay_timer #(.WIDTH(10), .RAND_W(7), .PULSE_LEN(3)) u_p3 (
        .clk(clk), .rst_n(rst_n), .trigger(p_trig), .abort(p_abort), .mode_rand(p_mode),
        .delay_fixed(p_fixed), .delay_min(p_min), .time_out(p_to), .busy(p_busy), .count(p_count)
    );

    rand_delay_timer #(.WIDTH(8), .RAND_W(7), .PULSE_LEN(1)) u_w8 (
        .clk(clk), .rst_n(rst_n), .trigger(w_trig), .abort(w_abort), .mode_rand(w_mode),
        .delay_fixed(w_fixed), .delay_min(w_min), .time_out(w_to), .busy(w_busy), .count(w_count)
    );

    // Reference LFSR: x^7 + x^6 + 1, right-shifting Galois form, seed 1
    logic [6:0] m_lfsr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 7'd1;
        else        m_lfsr <= {1'b0, m_lfsr[6:1]} ^ (m_lfsr[0] ? 7'b1100000 : 7'b0000000);
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if ({a_to, a_busy, a_count} !== 12'd0) $display("FAIL reset_a: got %b expected 0", {a_to, a_busy, a_count}); else n_pass++;
        n_checks++; if ({p_to, p_busy, p_count} !== 12'd0) $display("FAIL reset_p: got %b expected 0", {p_to, p_busy, p_count}); else n_pass++;
        n_checks++; if ({w_to, w_busy, w_count} !== 10'd0) $display("FAIL reset_w: got %b expected 0", {w_to, w_busy, w_count}); else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if ({a_to, a_busy, a_count} !== 12'd0) $display("FAIL post_reset_idle: got %b expected 0", {a_to, a_busy, a_count}); else n_pass++;
    endtask

    task automatic test_fixed_delay();
        logic [9:0] exp_cnt;
        a_mode = 1'b0; a_fixed = 10'd5; a_trig = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            // Mid-count input changes and a retrigger must not disturb the delay
            if (k == 0) begin a_trig = 1'b0; a_fixed = 10'd9; a_mode = 1'b1; a_min = 10'd3; end
            if (k == 2) a_trig = 1'b1;
            if (k == 3) a_trig = 1'b0;
            exp_cnt = (k <= 5) ? 10'(5 - k) : 10'd0;
            n_checks++; if (a_count !== exp_cnt) $display("FAIL fixed_count@%0d: got %0d expected %0d", k, a_count, exp_cnt); else n_pass++;
            n_checks++; if (a_busy !== (k <= 6)) $display("FAIL fixed_busy@%0d: got %b expected %b", k, a_busy, (k <= 6)); else n_pass++;
            n_checks++; if (a_to !== (k == 6)) $display("FAIL fixed_timeout@%0d: got %b expected %b", k, a_to, (k == 6)); else n_pass++;
        end
        a_mode = 1'b0;
    endtask

    task automatic test_zero_hold();
        int pulses;
        int first;
        a_mode = 1'b0; a_fixed = 10'd0; a_trig = 1'b1;
        pulses = 0; first = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (a_to) begin pulses++; if (first < 0) first = k; end
        end
        n_checks++; if (pulses !== 1) $display("FAIL hold_pulses: got %0d expected 1", pulses); else n_pass++;
        n_checks++; if (first !== 1) $display("FAIL zero_latency: got %0d expected 1", first); else n_pass++;
        n_checks++; if (a_busy !== 1'b0) $display("FAIL wait_low_busy: got %b expected 0", a_busy); else n_pass++;
        a_trig = 1'b0;
        @(negedge clk);
        a_trig = 1'b1;
        pulses = 0; first = -1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (a_to) begin pulses++; if (first < 0) first = k; end
        end
        n_checks++; if (first !== 1 || pulses !== 1) $display("FAIL rearm_pulse: got first=%0d n=%0d expected first=1 n=1", first, pulses); else n_pass++;
        a_trig = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_pulse_len();
        logic [7:0] hi;
        p_mode = 1'b0; p_fixed = 10'd2; p_trig = 1'b1;
        hi = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) p_trig = 1'b0;
            hi[k] = p_to;
        end
        n_checks++; if (hi !== 8'b0011_1000) $display("FAIL pulse_len3: got %b expected 00111000", hi); else n_pass++;
        // Abort during the pulse drops time_out on the next edge
        p_fixed = 10'd0; p_trig = 1'b1;
        @(negedge clk); p_trig = 1'b0;
        @(negedge clk);
        n_checks++; if (p_to !== 1'b1) $display("FAIL fire_entry: got %b expected 1", p_to); else n_pass++;
        p_abort = 1'b1;
        @(negedge clk); p_abort = 1'b0;
        n_checks++; if ({p_to, p_busy} !== 2'b00) $display("FAIL fire_abort: got %b expected 00", {p_to, p_busy}); else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++; if (p_to !== 1'b0) $display("FAIL fire_abort_stays: got %b expected 0", p_to); else n_pass++;
    endtask

    task automatic test_random();
        logic [9:0] exp_d;
        int k;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            exp_d = 10'd100 + {3'b000, m_lfsr};
            a_mode = 1'b1; a_min = 10'd100; a_trig = 1'b1;
            @(negedge clk);
            a_trig = 1'b0; a_fixed = 10'd7;
            n_checks++; if (a_count !== exp_d) $display("FAIL rand_load[%0d]: got %0d expected %0d", t, a_count, exp_d); else n_pass++;
            k = 0;
            while (!a_to && k < 400) begin @(negedge clk); k++; end
            n_checks++; if (k !== int'(exp_d) + 1) $display("FAIL rand_latency[%0d]: got %0d expected %0d", t, k, int'(exp_d) + 1); else n_pass++;
            n_checks++; if (!((k - 1) >= 101 && (k - 1) <= 227)) $display("FAIL rand_range[%0d]: got %0d expected 101..227", t, k - 1); else n_pass++;
            @(negedge clk);
        end
        a_mode = 1'b0;
    endtask

    task automatic test_saturation();
        int g;
        int k;
        g = 0;
        @(negedge clk);
        while (m_lfsr < 7'd6 && g < 300) begin @(negedge clk); g++; end
        n_checks++; if (m_lfsr < 7'd6) $display("FAIL sat_setup: got lfsr %0d expected >=6", m_lfsr); else n_pass++;
        w_mode = 1'b1; w_min = 8'd250; w_trig = 1'b1;
        @(negedge clk);
        w_trig = 1'b0;
        n_checks++; if (w_count !== 8'd255) $display("FAIL sat_load: got %0d expected 255", w_count); else n_pass++;
        k = 0;
        while (!w_to && k < 400) begin @(negedge clk); k++; end
        n_checks++; if (k !== 256) $display("FAIL sat_latency: got %0d expected 256", k); else n_pass++;
        @(negedge clk);
        n_checks++; if ({w_to, w_busy} !== 2'b00) $display("FAIL sat_end: got %b expected 00", {w_to, w_busy}); else n_pass++;
    endtask

    task automatic test_abort();
        logic seen;
        a_mode = 1'b0; a_fixed = 10'd5; a_trig = 1'b1;
        @(negedge clk); a_trig = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (a_count !== 10'd3) $display("FAIL abort_pre_count: got %0d expected 3", a_count); else n_pass++;
        a_abort = 1'b1;
        @(negedge clk); a_abort = 1'b0;
        n_checks++; if ({a_busy, a_count} !== 11'd0) $display("FAIL abort_idle: got %b expected 0", {a_busy, a_count}); else n_pass++;
        seen = 1'b0;
        repeat (10) begin @(negedge clk); seen |= a_to; end
        n_checks++; if (seen !== 1'b0) $display("FAIL abort_no_pulse: got %b expected 0", seen); else n_pass++;
        a_abort = 1'b1; a_trig = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if ({a_to, a_busy, a_count} !== 12'd0) $display("FAIL abort_wins: got %b expected 0", {a_to, a_busy, a_count}); else n_pass++;
        a_abort = 1'b0; a_trig = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic seen;
        a_mode = 1'b0; a_fixed = 10'd20; a_trig = 1'b1;
        @(negedge clk); a_trig = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (a_count !== 10'd17) $display("FAIL mid_count: got %0d expected 17", a_count); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({a_to, a_busy, a_count} !== 12'd0) $display("FAIL async_reset: got %b expected 0", {a_to, a_busy, a_count}); else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        seen = 1'b0;
        repeat (30) begin @(negedge clk); seen |= a_to | a_busy; end
        n_checks++; if (seen !== 1'b0) $display("FAIL reset_no_pulse: got %b expected 0", seen); else n_pass++;
    endtask

    initial begin
        a_trig = 0; a_abort = 0; a_mode = 0; a_fixed = 0; a_min = 0;
        p_trig = 0; p_abort = 0; p_mode = 0; p_fixed = 0; p_min = 0;
        w_trig = 0; w_abort = 0; w_mode = 0; w_fixed = 0; w_min = 0;
        rst_n = 1'b0;
        test_reset();
        test_fixed_delay();
        test_zero_hold();
        test_pulse_len();
        test_random();
        test_saturation();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/rand_delay_timer.md
Name: rand_delay_timer

Overview:
Programmable trigger-to-pulse delay timer: the next generation of the Lab 3 reaction-timer delay block. A trigger arms a countdown whose length is either a fixed value or a random offset added to a minimum. When the countdown expires, the block emits a time_out pulse of configurable width. Abort, busy and live-count outputs let the top-level FSM and the 7-segment display track and cancel the delay.

Parameters:
WIDTH, 10, bits in the delay counter and delay inputs
RAND_W, 7, LFSR width (1..WIDTH); the random offset is zero-extended to WIDTH
PULSE_LEN, 1, cycles time_out stays high per expiry (>=1)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
trigger  input  1  level start request
abort  input  1  cancel an in-flight delay; no pulse is emitted
mode_rand  input  1  1 = random delay, 0 = fixed delay; sampled at load only
delay_fixed  input  WIDTH  delay D used when mode_rand=0
delay_min  input  WIDTH  base added to the random offset when mode_rand=1
time_out  output  1  expiry pulse, high for PULSE_LEN cycles
busy  output  1  high in COUNTING and FIRE
count  output  WIDTH  remaining count; 0 outside COUNTING

Behaviour:
- One clock domain, clk. Reset is asynchronous, active-low (rst_n).
- Reset state: state=IDLE, count=0, pulse counter=0, time_out=0, busy=0, LFSR=seed 1 (never all-zero).
- LFSR: free-running, advances every cycle; its taps give maximal length for RAND_W.
- States: IDLE, COUNTING, FIRE, WAIT_LOW. Outputs are Moore, registered from the state only.
- IDLE: if trigger=1 and abort=0, load count and go to COUNTING.
  - Load value = delay_fixed (mode_rand=0).
  - Or delay_min + lfsr (mode_rand=1), computed at WIDTH+1 bits and saturated to all-ones on overflow.
  - The lfsr value used is the one present in the loading cycle.
- COUNTING: if count!=0, decrement; if count==0, go to FIRE and load the pulse counter with PULSE_LEN-1.
- Latency:
  - With trigger sampled at edge 0 and a load value D, time_out is first high after edge D+1.
  - It stays high exactly PULSE_LEN cycles.
  - D=0 gives time_out after edge 1.
- FIRE: time_out=1. The pulse counter decrements; at 0, go to WAIT_LOW if trigger=1, else IDLE.
- WAIT_LOW: time_out=0; return to IDLE when trigger=0. This prevents a held trigger from re-arming.
- Retrigger: trigger is ignored in COUNTING and FIRE; the current delay is not restarted.
- Abort:
  - In COUNTING or FIRE: go to IDLE at the next edge, clear count, drop time_out immediately on that edge.
  - Abort and trigger together in IDLE: abort wins, no load.
  - In WAIT_LOW: no effect.
- mode_rand, delay_fixed and delay_min changes mid-count do not affect the running delay.
- Reset mid-operation: immediate return to the reset state, with no pulse on deassertion.
- Unreachable state encodings: go to IDLE, with outputs low.

Decomposition:
- Package rand_delay_pkg:
  - state enum typedef (IDLE, COUNTING, FIRE, WAIT_LOW);
  - function returning the maximal-length tap mask for RAND_W 3..16;
  - LFSR seed constant.
- Sub-module lfsr_n:
  - parameter N, ports clk, rst_n, en, data_out[N];
  - en tied high here;
  - replaces the fixed-width LFSR.
- Top level holds the FSM, the delay counter, the pulse counter and the saturating adder.

Test Plan:
- Fixed mode, delay_fixed=5, PULSE_LEN=1, trigger 1 cycle at edge 0 -> time_out high only in the cycle after edge 6; busy high edges 0..6; count shows 5,4,3,2,1,0.
- delay_fixed=0 -> time_out after edge 1; trigger held high 20 cycles -> exactly one pulse, then WAIT_LOW until trigger drops; re-raise -> second pulse.
- PULSE_LEN=3, delay_fixed=2 -> time_out high exactly 3 consecutive cycles, starting after edge 3.
- Random mode, delay_min=100, 200 trials -> each delay equals 100 + lfsr at load (checked against a model); all delays within 101..227; never 0.
- Saturation, WIDTH=8: delay_min=250 with lfsr≥6 -> load 255, time_out after edge 256.
- Abort at count=3 -> IDLE next edge, no time_out ever; abort together with trigger in IDLE -> stays IDLE; rst_n low mid-COUNTING -> outputs 0 asynchronously.
